// File: rtl/dsp_sys_arr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_sys_arr_pkg
// Brief    : Shared types and width helpers for the systolic-array feed path.
// Revision : 1.0
// ============================================================================
package dsp_sys_arr_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } feed_state_t;

  function automatic int occ_width(input int size);
    return $clog2(size) + 1;
  endfunction

  // The skew counter must reach SIZE+N-2, and the window top i+K reaches SIZE+N-1.
  function automatic int skew_cnt_width(input int n, input int size);
    return $clog2(size + n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : skew_feed_ctrl_if
// Brief    : Control/status and FIFO pop/occupancy bundle for skew_feed_ctrl.
// Revision : 1.0
// ============================================================================
interface skew_feed_ctrl_if
  import dsp_sys_arr_pkg::*;
#(
  parameter int N    = 4,
  parameter int SIZE = 16
);

  localparam int c_OW = occ_width(SIZE);

  logic                start;
  logic [c_OW-1:0]     k_len;
  logic                abort;
  logic [N*c_OW-1:0]   ocp;
  logic [N-1:0]        pop;
  logic [N-1:0]        row_valid;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, k_len, abort, ocp,
    input  pop, row_valid, busy, done, err
  );

  modport slave (
    input  start, k_len, abort, ocp,
    output pop, row_valid, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/skew_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : skew_feed_ctrl
// Brief    : Issues diagonally skewed pop bursts to N row FIFOs feeding a
//            systolic array edge, gated on every FIFO holding K words.
// Revision : 1.0
// ============================================================================
module skew_feed_ctrl
  import dsp_sys_arr_pkg::*;
#(
  parameter int N    = 4,
  parameter int SIZE = 16
)(
  input  wire logic        CLK,
  input  wire logic        RST,
  skew_feed_ctrl_if.slave  bus
);

  localparam int c_OW = occ_width(SIZE);
  localparam int c_TW = skew_cnt_width(N, SIZE);

  localparam logic [1:0] c_ST_IDLE = IDLE;
  localparam logic [1:0] c_ST_WAIT = WAIT;
  localparam logic [1:0] c_ST_RUN  = RUN;
  localparam logic [1:0] c_ST_DONE = DONE;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_TW-1:0] r_t;
  logic [c_OW-1:0] r_k;
  logic            r_err;

  logic [N-1:0]    w_ocp_ok;
  logic [N-1:0]    w_win;
  logic [N-1:0]    w_pop;
  logic            w_k_ok;
  logic            w_accept;
  logic            w_gate_open;
  logic            w_last;

  assign w_k_ok      = (bus.k_len != '0) && (bus.k_len <= c_OW'(SIZE));
  assign w_accept    = (r_state == c_ST_IDLE) && bus.start && w_k_ok;
  assign w_gate_open = &w_ocp_ok;
  // Last RUN cycle is t == K+N-2; K >= 1 keeps the modular form exact for N == 1.
  assign w_last      = (r_t == (c_TW'(r_k) + c_TW'(N) - c_TW'(2)));

  // Per-row occupancy gate and diagonal pop window [i, i+K).
  for (genvar i = 0; i < N; i++) begin : g_row
    assign w_ocp_ok[i] = (bus.ocp[i*c_OW +: c_OW] >= r_k);
    assign w_win[i]    = (r_t >= c_TW'(i)) && (r_t < (c_TW'(i) + c_TW'(r_k)));
  end

  assign w_pop         = ((r_state == c_ST_RUN) && !bus.abort) ? w_win : '0;
  assign bus.pop       = w_pop;
  assign bus.row_valid = w_pop;
  assign bus.busy      = (r_state == c_ST_WAIT) || (r_state == c_ST_RUN);
  assign bus.done      = (r_state == c_ST_DONE);
  assign bus.err       = r_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) w_state_nxt = c_ST_WAIT;
      end
      c_ST_WAIT: begin
        if (bus.abort)        w_state_nxt = c_ST_IDLE;
        else if (w_gate_open) w_state_nxt = c_ST_RUN;
      end
      c_ST_RUN: begin
        if (bus.abort)   w_state_nxt = c_ST_IDLE;
        else if (w_last) w_state_nxt = c_ST_DONE;
      end
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_ST_IDLE;
      r_t     <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= (r_state == c_ST_IDLE) && bus.start && !w_k_ok;
      if (w_accept) r_k <= bus.k_len;
      // t restarts at 0 on every entry into RUN.
      if ((r_state == c_ST_RUN) && (w_state_nxt == c_ST_RUN)) r_t <= r_t + c_TW'(1);
      else                                                   r_t <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_skew_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_skew_feed_ctrl
// Brief    : Scoreboard bench for skew_feed_ctrl with FIFO occupancy model.
// Revision : 1.0
// ============================================================================
module tb_skew_feed_ctrl;
  import dsp_sys_arr_pkg::*;

  localparam int N       = 4;
  localparam int SIZE    = 16;
  localparam int OW      = $clog2(SIZE) + 1;
  localparam int EV_POP  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] vec;
    int           off;
  } ev_t;

  logic CLK = 1'b0;
  logic RST;
  logic ld;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   base_cyc = 0;
  int   occ[N];
  int   ld_val[N];
  ev_t  exp_q[$];

  skew_feed_ctrl_if #(.N(N), .SIZE(SIZE)) bus ();

  skew_feed_ctrl #(.N(N), .SIZE(SIZE)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_ocp
    assign bus.ocp[g*OW +: OW] = OW'(occ[g]);
  end

  // External FIFOs: occupancy only, consumer is the DUT's pop.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++)
      occ[i] <= ld ? ld_val[i] : occ[i] - int'(bus.pop[i]);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Row i is fed during burst offsets i .. i+K-1.
  function automatic logic [N-1:0] exp_vec(input int k, input int c);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = (c >= i) && (c < i + k);
    return v;
  endfunction

  function automatic int n_pops(input int k, input int row, input int ncyc);
    int hi;
    hi = (ncyc < row + k) ? ncyc : row + k;
    return (hi > row) ? hi - row : 0;
  endfunction

  always @(negedge CLK) begin : mon
    ev_t e;
    int  kind;
    for (int i = 0; i < N; i++)
      if (bus.pop[i]) chk("pop_nonempty_row", int'(occ[i] > 0), 1);
    if (bus.pop != 0 || bus.row_valid != 0 || bus.done || bus.err) begin
      kind = bus.err ? EV_ERR : (bus.done ? EV_DONE : EV_POP);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: actual kind=%0d pop=%b done=%b err=%b required none",
                 kind, bus.pop, bus.done, bus.err);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (e.kind == EV_POP) begin
          chk("pop_vec", int'(bus.pop), int'(e.vec));
          chk("row_valid_vec", int'(bus.row_valid), int'(e.vec));
          if (e.off == 0) base_cyc = cyc;
          else            chk("pop_offset", cyc - base_cyc, e.off);
        end else if (e.kind == EV_DONE) begin
          chk("done_offset", cyc - base_cyc, e.off);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_all(input int v[N]);
    ld_val = v;
    ld     = 1'b1;
    tick();
    ld     = 1'b0;
  endtask

  task automatic wait_run(output int nwait, output bit ok);
    nwait = 0;
    ok    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (bus.pop != 0) begin
        ok = 1'b1;
        break;
      end
      nwait++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL run_timeout: actual=no pop in 100 cycles required=pop");
    end
  endtask

  task automatic bad_start(input int k);
    ev_t e;
    e.kind = EV_ERR; e.vec = '0; e.off = 0;
    exp_q.push_back(e);
    bus.start = 1'b1;
    bus.k_len = OW'(k);
    tick();
    bus.start = 1'b0;
    chk("err_busy", int'(bus.busy), 0);
    tick();
    chk("err_busy_after", int'(bus.busy), 0);
  endtask

  task automatic burst(input int k, input int abort_at, input int rst_at, input bit ign_run,
                       input bit start_in_done, input bit abort_with_start, input int gate_hold);
    int  init[N];
    int  ncyc;
    int  nw;
    bit  ok;
    ev_t e;
    ncyc = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at + 1 : k + N - 1);
    for (int c = 0; c < ncyc; c++) begin
      e.kind = EV_POP; e.vec = exp_vec(k, c); e.off = c;
      exp_q.push_back(e);
    end
    if (abort_at < 0 && rst_at < 0) begin
      e.kind = EV_DONE; e.vec = '0; e.off = k + N - 1;
      exp_q.push_back(e);
    end
    bus.start = 1'b1;
    bus.k_len = OW'(k);
    bus.abort = abort_with_start;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("busy_in_wait", int'(bus.busy), 1);
    if (gate_hold > 0) begin
      repeat (gate_hold) begin
        @(negedge CLK);
        chk("gate_pop", int'(bus.pop), 0);
        chk("gate_busy", int'(bus.busy), 1);
      end
      tick();
      ld_val    = occ;
      ld_val[1] = k;
      ld        = 1'b1;
      tick();
      ld        = 1'b0;
    end
    init = occ;
    wait_run(nw, ok);
    if (!ok) begin
      exp_q.delete();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      return;
    end
    chk("wait_cycles", nw, 1);
    for (int t = 1; t <= k + N - 2; t++) begin
      tick();
      bus.start = 1'b0;
      if (t == abort_at) begin
        bus.abort = 1'b1;
        @(negedge CLK);
        chk("abort_pop", int'(bus.pop), 0);
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        break;
      end
      if (t == rst_at) begin
        RST = 1'b1;
        tick();
        chk("rst_outs", int'({bus.pop, bus.row_valid, bus.busy, bus.done, bus.err}), 0);
        RST = 1'b0;
        break;
      end
      if (ign_run && ($urandom_range(0, 1) == 1)) begin
        bus.start = 1'b1;
        bus.k_len = OW'($urandom_range(0, 31));
      end
    end
    if (abort_at < 0 && rst_at < 0) begin
      tick();
      bus.start = start_in_done;
      bus.k_len = '0;
      chk("busy_in_done", int'(bus.busy), 0);
      tick();
      bus.start = 1'b0;
      chk("busy_after_done", int'(bus.busy), 0);
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("ocp_row%0d", i), occ[i], init[i] - n_pops(k, i, ncyc));
    tick();
  endtask

  initial begin
    int v[N];
    int k;
    int mode;
    RST       = 1'b1;
    ld        = 1'b0;
    ld_val    = '{default: 0};
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.abort = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("outs_in_reset", int'({bus.pop, bus.row_valid, bus.busy, bus.done, bus.err}), 0);
    end
    tick();
    RST = 1'b0;
    tick();
    chk("outs_idle", int'({bus.pop, bus.row_valid, bus.busy, bus.done, bus.err}), 0);

    load_all('{4, 4, 4, 4});
    burst(3, -1, -1, 1'b0, 1'b0, 1'b0, 0);

    load_all('{16, 2, 16, 16});
    burst(5, -1, -1, 1'b0, 1'b0, 1'b0, 6);

    bad_start(0);
    bad_start(17);
    load_all('{16, 16, 16, 16});
    burst(16, -1, -1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) chk("full_burst_empty", occ[i], 0);

    load_all('{16, 16, 16, 16});
    burst(8, 2, -1, 1'b0, 1'b0, 1'b0, 0);

    load_all('{16, 16, 16, 16});
    burst(8, -1, 4, 1'b0, 1'b0, 1'b0, 0);
    burst(2, -1, -1, 1'b0, 1'b0, 1'b0, 0);

    load_all('{16, 16, 16, 16});
    burst(6, -1, -1, 1'b1, 1'b1, 1'b0, 0);

    load_all('{8, 8, 8, 8});
    burst(3, -1, -1, 1'b0, 1'b0, 1'b1, 0);

    for (int it = 0; it < 24; it++) begin
      k    = $urandom_range(1, SIZE);
      mode = $urandom_range(0, 9);
      for (int i = 0; i < N; i++) v[i] = $urandom_range(k, SIZE);
      if (mode == 3) v[1] = $urandom_range(0, k - 1);
      load_all(v);
      case (mode)
        0:       bad_start(($urandom_range(0, 1) == 1) ? 0 : $urandom_range(SIZE + 1, 31));
        1:       burst(k, $urandom_range(1, k + N - 2), -1, 1'b1, 1'b0, 1'b0, 0);
        2:       burst(k, -1, $urandom_range(1, k + N - 2), 1'b1, 1'b0, 1'b0, 0);
        3:       burst(k, -1, -1, 1'b0, 1'b1, 1'b0, $urandom_range(1, 4));
        default: burst(k, -1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 0);
      endcase
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
